flow_control_np: RTL

// - Credit-based pipeline flow control for an NPORT-port mesh router; successor of the fixed 4-port full-flag scheme.
// - Per output: tracks downstream buffer credits, grants the switch-selected input, and counts each flit sent.
// - Per input: generates stage-advance and FIFO-pop enables, and returns one registered credit upstream per pop.
// - Sits between the switch allocator and the input FIFOs / crossbar pipeline register.

---
 rtl/flow_control_np_pkg.sv | 23 ++
 rtl/flow_control_np_credit_counter.sv | 53 +++++
 rtl/flow_control_np.sv | 110 +++++++++++
 3 files changed

// File: rtl/flow_control_np_pkg.sv
// Shared switch-select codes and selection-legality helper for the credit flow-control block.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package flow_control_np_pkg;

  // Default width of one switch-select code
  localparam int SW_W_DEF = 3;

  // Switch-select code of each port equals its port index
  localparam int SW_X1    = 0;
  localparam int SW_X2    = 1;
  localparam int SW_Y1    = 2;
  localparam int SW_LOCAL = 3;

  // All-ones code never names a real port, so it always means "no selection"
  localparam logic [SW_W_DEF-1:0] SW_NONE = '1;

  // A selection counts only when flagged valid and the code names an existing port
  function automatic logic sw_legal(input logic vld, input int code, input int nport);
    return vld && (code < nport);
  endfunction

endpackage

// File: rtl/flow_control_np_credit_counter.sv
// Per-output downstream credit counter: decrements on send, increments on returned credit, saturates at DEPTH.
// Latency: count updates one clk after dec/inc; nz_o is the registered count compared with zero.
// Backpressure: nz_o=0 blocks sends; a credit arriving at zero only becomes usable the next cycle.
module flow_control_np_credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          nz_o,
  output logic          err_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Next count: send and return together cancel; an extra credit at full is flagged, not counted
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({dec_i, inc_i})
      2'b10: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      2'b01: begin
        if (cnt_q < FULL) cnt_d = cnt_q + CW'(1);
        else              err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Count and sticky error register; reset restores a full set of credits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);
  assign err_o = err_q;

endmodule

// File: rtl/flow_control_np.sv
// Credit-based flow control for an NPORT router: grants switch selections, advances stages, returns credits.
// Latency: en_stage/en_fifo/flit_sent combinational; credit_out and credit_cnt registered (1 clk).
// Backpressure: a stage holding a flit stalls while its granted output has zero downstream credit.
module flow_control_np
  import flow_control_np_pkg::*;
#(
  parameter  int NPORT = 4,
  parameter  int SW_W  = 3,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT*SW_W-1:0] out_sw,
  input  logic [NPORT-1:0]      out_sw_vld,
  input  logic [NPORT-1:0]      valid_in,
  input  logic [NPORT-1:0]      empty_in,
  input  logic [NPORT-1:0]      credit_in,
  output logic [NPORT-1:0]      en_stage,
  output logic [NPORT-1:0]      en_fifo,
  output logic [NPORT-1:0]      flit_sent,
  output logic [NPORT-1:0]      credit_out,
  output logic [NPORT*CW-1:0]   credit_cnt,
  output logic                  credit_err
);

  logic [SW_W-1:0]        sel_code [NPORT];
  logic [NPORT-1:0]       sel_lgl;
  // grant_flat[i*NPORT+o] = output o has been granted to input i
  logic [NPORT*NPORT-1:0] grant_flat;
  logic [NPORT-1:0]       cnt_nz;
  logic [NPORT-1:0]       err_vec;
  logic [NPORT-1:0]       credit_out_q, credit_out_d;

  // Split the packed select bus and drop out-of-range or unflagged codes
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      sel_code[o] = out_sw[o*SW_W +: SW_W];
      sel_lgl[o]  = sw_legal(out_sw_vld[o], int'(sel_code[o]), NPORT);
    end
  end

  // Per input, the lowest-index output selecting it wins; the rest see no selection
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_grant
    logic [NPORT-1:0] win;
    logic             found;

    // Priority scan over outputs, lowest index first
    always_comb begin
      win   = '0;
      found = 1'b0;
      for (int o = 0; o < NPORT; o++) begin
        if (!found && sel_lgl[o] && (sel_code[o] == SW_W'(gi))) begin
          win[o] = 1'b1;
          found  = 1'b1;
        end
      end
    end

    assign grant_flat[gi*NPORT +: NPORT] = win;
  end

  // A flit crosses when the granted input holds one and the output has credit
  always_comb begin
    flit_sent = '0;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (grant_flat[i*NPORT + o] && valid_in[i]) flit_sent[o] = cnt_nz[o];
      end
    end
  end

  // Empty stages always advance; full ones only when their flit actually leaves
  always_comb begin
    en_stage = '0;
    en_fifo  = '0;
    for (int i = 0; i < NPORT; i++) begin
      en_stage[i] = ~valid_in[i] | (|(grant_flat[i*NPORT +: NPORT] & flit_sent));
      en_fifo[i]  = en_stage[i] & ~empty_in[i];
    end
  end

  // One credit counter per output
  for (genvar go = 0; go < NPORT; go++) begin : g_cnt
    flow_control_np_credit_counter #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .dec_i (flit_sent[go]),
      .inc_i (credit_in[go]),
      .cnt_o (credit_cnt[go*CW +: CW]),
      .nz_o  (cnt_nz[go]),
      .err_o (err_vec[go])
    );
  end

  assign credit_err   = |err_vec;
  assign credit_out_d = en_fifo;

  // Each FIFO pop returns exactly one credit upstream on the following cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credit_out_q <= '0;
    else        credit_out_q <= credit_out_d;
  end

  assign credit_out = credit_out_q;

endmodule
